// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side inputs plus hazard controls in, register-file
// write port, previous-write history and retire count out.
interface mem_wb_stage_if;
    logic        mem_valid;
    logic        stall;
    logic        flush;
    logic        RegWrite;
    logic [1:0]  MemtoReg;
    logic [4:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus8;

    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        hist_valid;
    logic [4:0]  hist_addr;
    logic [31:0] hist_data;
    logic [31:0] retired_count;

    modport master (
        output mem_valid, stall, flush, RegWrite, MemtoReg, write_reg,
               alu_result, read_data, pc_plus8,
        input  reg_write_en, reg_write_addr, reg_write_data,
               hist_valid, hist_addr, hist_data, retired_count
    );

    modport slave (
        input  mem_valid, stall, flush, RegWrite, MemtoReg, write_reg,
               alu_result, read_data, pc_plus8,
        output reg_write_en, reg_write_addr, reg_write_data,
               hist_valid, hist_addr, hist_data, retired_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback select, one-deep write history for
// ID-stage bypass, and a retired-instruction counter.
module mem_wb_stage (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    logic        valid_q,     valid_d;
    logic        regwrite_q,  regwrite_d;
    logic [1:0]  memtoreg_q,  memtoreg_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] alu_q,       alu_d;
    logic [31:0] mem_q,       mem_d;
    logic [31:0] link_q,      link_d;

    logic        hist_valid_q;
    logic [4:0]  hist_addr_q;
    logic [31:0] hist_data_q;

    logic [31:0] retired_count_q, retired_count_d;

    logic        wr_en_s;
    logic [31:0] wr_data_s;
    logic        retire_s;

    // MEM/WB next state: flush beats stall, stall holds, otherwise load
    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        write_reg_d = write_reg_q;
        alu_d       = alu_q;
        mem_d       = mem_q;
        link_d      = link_q;
        if (bus.flush) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            memtoreg_d  = 2'b00;
            write_reg_d = 5'd0;
            alu_d       = 32'd0;
            mem_d       = 32'd0;
            link_d      = 32'd0;
        end else if (!bus.stall) begin
            valid_d     = bus.mem_valid;
            regwrite_d  = bus.RegWrite & bus.mem_valid;
            memtoreg_d  = bus.MemtoReg;
            write_reg_d = bus.write_reg;
            alu_d       = bus.alu_result;
            mem_d       = bus.read_data;
            link_d      = bus.pc_plus8;
        end else begin
            valid_d     = valid_q;
        end
    end

    // Writeback value select; the reserved encoding falls back to the ALU
    always_comb begin
        wr_data_s = alu_q;
        case (memtoreg_q)
            2'b01:   wr_data_s = mem_q;
            2'b10:   wr_data_s = link_q;
            default: wr_data_s = alu_q;
        endcase
    end

    assign wr_en_s  = valid_q & regwrite_q & (write_reg_q != 5'd0);
    assign retire_s = valid_q & (~bus.stall | bus.flush);

    // Retire counter next state, wraps modulo 2^32
    always_comb begin
        if (retire_s) begin
            retired_count_d = retired_count_q + 32'd1;
        end else begin
            retired_count_d = retired_count_q;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 2'b00;
            write_reg_q <= 5'd0;
            alu_q       <= 32'd0;
            mem_q       <= 32'd0;
            link_q      <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            write_reg_q <= write_reg_d;
            alu_q       <= alu_d;
            mem_q       <= mem_d;
            link_q      <= link_d;
        end
    end

    // History tracks every edge, even under stall/flush; a repeated write is harmless
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_valid_q <= 1'b0;
            hist_addr_q  <= 5'd0;
            hist_data_q  <= 32'd0;
        end else begin
            hist_valid_q <= wr_en_s;
            hist_addr_q  <= write_reg_q;
            hist_data_q  <= wr_data_s;
        end
    end

    // Retire counter register; reset discards any simultaneous retire
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_count_q <= 32'd0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign bus.reg_write_en   = wr_en_s;
    assign bus.reg_write_addr = write_reg_q;
    assign bus.reg_write_data = wr_data_s;
    assign bus.hist_valid     = hist_valid_q;
    assign bus.hist_addr      = hist_addr_q;
    assign bus.hist_data      = hist_data_q;
    assign bus.retired_count  = retired_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic clk;
    logic rst;
    int   checks_cnt;
    int   errors_cnt;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic rw, input logic [1:0] mtr,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] pc);
        bus.mem_valid  = v;
        bus.RegWrite   = rw;
        bus.MemtoReg   = mtr;
        bus.write_reg  = wr;
        bus.alu_result = alu;
        bus.read_data  = rd;
        bus.pc_plus8   = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    {31'd0, bus.reg_write_en},   32'd0);
        chk({tag, "_addr"},  {27'd0, bus.reg_write_addr}, 32'd0);
        chk({tag, "_data"},  bus.reg_write_data,          32'd0);
        chk({tag, "_hv"},    {31'd0, bus.hist_valid},     32'd0);
        chk({tag, "_ha"},    {27'd0, bus.hist_addr},      32'd0);
        chk({tag, "_hd"},    bus.hist_data,               32'd0);
        chk({tag, "_cnt"},   bus.retired_count,           32'd0);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst        = 1'b1;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        drv(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        chk_all_zero("rst");
        rst = 1'b0;

        // ALU writeback
        drv(1'b1, 1'b1, 2'b00, 5'd5, 32'h0000_1234, 32'h0000_9999, 32'h0000_0010);
        step();
        chk("alu_en",   {31'd0, bus.reg_write_en},   32'd1);
        chk("alu_addr", {27'd0, bus.reg_write_addr}, 32'd5);
        chk("alu_data", bus.reg_write_data,          32'h0000_1234);
        chk("alu_hv",   {31'd0, bus.hist_valid},     32'd0);
        chk("alu_cnt",  bus.retired_count,           32'd0);

        // Load-word writeback
        drv(1'b1, 1'b1, 2'b01, 5'd8, 32'h0000_5555, 32'hDEAD_BEEF, 32'h0000_0020);
        step();
        chk("lw_addr", {27'd0, bus.reg_write_addr}, 32'd8);
        chk("lw_data", bus.reg_write_data,          32'hDEAD_BEEF);
        chk("lw_hv",   {31'd0, bus.hist_valid},     32'd1);
        chk("lw_ha",   {27'd0, bus.hist_addr},      32'd5);
        chk("lw_hd",   bus.hist_data,               32'h0000_1234);
        chk("lw_cnt",  bus.retired_count,           32'd1);

        // Link writeback
        drv(1'b1, 1'b1, 2'b10, 5'd31, 32'h0000_6666, 32'h0000_7777, 32'h0000_0040);
        step();
        chk("lnk_addr", {27'd0, bus.reg_write_addr}, 32'd31);
        chk("lnk_data", bus.reg_write_data,          32'h0000_0040);
        chk("lnk_hd",   bus.hist_data,               32'hDEAD_BEEF);
        chk("lnk_cnt",  bus.retired_count,           32'd2);

        // Reserved select behaves as ALU
        drv(1'b1, 1'b1, 2'b11, 5'd3, 32'h0000_0077, 32'h0000_0099, 32'h0000_0088);
        step();
        chk("rsv_data", bus.reg_write_data, 32'h0000_0077);
        chk("rsv_cnt",  bus.retired_count,  32'd3);

        // Write to $0 is suppressed but still retires
        drv(1'b1, 1'b1, 2'b00, 5'd0, 32'h0000_AAAA, 32'd0, 32'd0);
        step();
        chk("r0_en",  {31'd0, bus.reg_write_en}, 32'd0);
        chk("r0_cnt", bus.retired_count,         32'd4);

        // Bubble with RegWrite high: no write, no count
        drv(1'b0, 1'b1, 2'b00, 5'd9, 32'h0000_BBBB, 32'd0, 32'd0);
        step();
        chk("bub_en",  {31'd0, bus.reg_write_en}, 32'd0);
        chk("r0_hv",   {31'd0, bus.hist_valid},   32'd0);
        chk("bub_cnt", bus.retired_count,         32'd5);
        step();
        chk("bub2_cnt", bus.retired_count, 32'd5);

        // Stall three edges on a valid instruction
        drv(1'b1, 1'b1, 2'b00, 5'd10, 32'h0000_1010, 32'd0, 32'd0);
        step();
        chk("stl0_data", bus.reg_write_data, 32'h0000_1010);
        chk("stl0_cnt",  bus.retired_count,  32'd5);
        bus.stall = 1'b1;
        drv(1'b1, 1'b1, 2'b01, 5'd11, 32'h0000_2020, 32'h0000_3131, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_en",   {31'd0, bus.reg_write_en},   32'd1);
            chk("stl_addr", {27'd0, bus.reg_write_addr}, 32'd10);
            chk("stl_data", bus.reg_write_data,          32'h0000_1010);
            chk("stl_ha",   {27'd0, bus.hist_addr},      32'd10);
            chk("stl_cnt",  bus.retired_count,           32'd5);
        end
        bus.stall = 1'b0;
        drv(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("rel_en",  {31'd0, bus.reg_write_en}, 32'd0);
        chk("rel_cnt", bus.retired_count,         32'd6);

        // Flush together with stall: instruction retires, bubble loads
        drv(1'b1, 1'b1, 2'b00, 5'd12, 32'h0000_3030, 32'd0, 32'd0);
        step();
        chk("fl0_en",  {31'd0, bus.reg_write_en}, 32'd1);
        chk("fl0_cnt", bus.retired_count,         32'd6);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        chk("fl_en",   {31'd0, bus.reg_write_en},   32'd0);
        chk("fl_addr", {27'd0, bus.reg_write_addr}, 32'd0);
        chk("fl_data", bus.reg_write_data,          32'd0);
        chk("fl_cnt",  bus.retired_count,           32'd7);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drv(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("fl_bub_cnt", bus.retired_count, 32'd7);

        // Counter wrap from preset all-ones
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        drv(1'b1, 1'b1, 2'b00, 5'd4, 32'h0000_4444, 32'd0, 32'd0);
        step();
        chk("wrap_hold", bus.retired_count, 32'hFFFF_FFFF);
        drv(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("wrap_cnt", bus.retired_count, 32'd0);

        // Reset during an active, stalled write
        drv(1'b1, 1'b1, 2'b00, 5'd6, 32'h0000_6666, 32'd0, 32'd0);
        step();
        chk("pre_rst_en", {31'd0, bus.reg_write_en}, 32'd1);
        rst       = 1'b1;
        bus.stall = 1'b1;
        step();
        chk_all_zero("mid_rst");
        rst       = 1'b0;
        bus.stall = 1'b0;
        drv(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("post_rst_cnt", bus.retired_count,         32'd0);
        chk("post_rst_en",  {31'd0, bus.reg_write_en}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
